// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a qualified lock, then releases sys_rst.
// Define PLL_LOCK_SEQ_STATS_EN to build the saturating loss-of-lock and timeout event counters.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic [1:0] state_o,
    output logic [7:0] lol_count,
    output logic [7:0] timeout_count
);
    typedef enum logic [1:0] {
        RESET_PLL = 2'b00,
        WAIT_LOCK = 2'b01,
        STABILIZE = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam int MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] LAST_RST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LAST_ST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LAST_TO  = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_q, lk_s_q;
    logic          pll_rst_q, sys_rst_q, lock_ok_q;

    // Lock always beats an expiring timeout in WAIT_LOCK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == LAST_RST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_TO) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_ST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            sync_q    <= 1'b0;
            lk_s_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= pll_locked;
            lk_s_q    <= sync_q;
            pll_rst_q <= (state_d == RESET_PLL);
            sys_rst_q <= (state_d != RUN);
            lock_ok_q <= (state_d == RUN);
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign lock_ok = lock_ok_q;
    assign state_o = state_q;

`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0] lol_q, to_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            lol_q <= 8'd0;
            to_q  <= 8'd0;
        end else begin
            if (state_q == RUN && !lk_s_q && lol_q != 8'hFF) begin
                lol_q <= lol_q + 8'd1;
            end
            if (state_q == WAIT_LOCK && !lk_s_q && cnt_q == LAST_TO && to_q != 8'hFF) begin
                to_q <= to_q + 8'd1;
            end
        end
    end

    assign lol_count     = lol_q;
    assign timeout_count = to_q;
`else
    assign lol_count     = 8'd0;
    assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/dwell reference model queues the expected outputs
// for every driven cycle and a monitor compares them against the DUT one edge later.
module tb_pll_lock_sequencer;
    localparam int PLL_RST_CYCLES = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;

    typedef struct packed {
        logic       pllRst;
        logic       sysRst;
        logic       lockOk;
        logic [1:0] state;
        logic [7:0] lol;
        logic [7:0] tmo;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, lock_ok;
    logic [1:0] state_o;
    logic [7:0] lol_count, timeout_count;

    int   testsRun = 0;
    int   failCount = 0;
    int   cycle = 0;
    exp_t expQ[$];

    // Reference model: phase, cycles completed in that phase, and a two-deep lock delay line.
    int   mPhase = PH_RESET;
    int   mDwell = 0;
    int   mLol = 0;
    int   mTo = 0;
    logic hist[$] = '{1'b0, 1'b0};

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .lock_ok      (lock_ok),
        .state_o      (state_o),
        .lol_count    (lol_count),
        .timeout_count(timeout_count)
    );

    always #5 refclk = ~refclk;

    task automatic modelStep(input logic r, input logic l);
        logic lk;
        if (r) begin
            mPhase = PH_RESET;
            mDwell = 0;
            mLol   = 0;
            mTo    = 0;
            hist   = '{1'b0, 1'b0};
            return;
        end
        lk = hist.pop_front();
        hist.push_back(l);
        case (mPhase)
            PH_RESET: begin
                mDwell++;
                if (mDwell == PLL_RST_CYCLES) begin
                    mPhase = PH_WAIT;
                    mDwell = 0;
                end
            end
            PH_WAIT: begin
                if (lk) begin
                    mPhase = PH_STAB;
                    mDwell = 0;
                end else begin
                    mDwell++;
                    if (mDwell == TIMEOUT_CYCLES) begin
                        mPhase = PH_RESET;
                        mDwell = 0;
                        if (mTo < 255) mTo++;
                    end
                end
            end
            PH_STAB: begin
                if (!lk) begin
                    mPhase = PH_WAIT;
                    mDwell = 0;
                end else begin
                    mDwell++;
                    if (mDwell == STABLE_CYCLES) begin
                        mPhase = PH_RUN;
                        mDwell = 0;
                    end
                end
            end
            default: begin
                if (!lk) begin
                    mPhase = PH_WAIT;
                    mDwell = 0;
                    if (mLol < 255) mLol++;
                end
            end
        endcase
    endtask

    function automatic exp_t expectedNow();
        exp_t e;
        e.pllRst = (mPhase == PH_RESET);
        e.sysRst = (mPhase != PH_RUN);
        e.lockOk = (mPhase == PH_RUN);
        e.state  = 2'(mPhase);
`ifdef PLL_LOCK_SEQ_STATS_EN
        e.lol    = 8'(mLol);
        e.tmo    = 8'(mTo);
`else
        e.lol    = 8'd0;
        e.tmo    = 8'd0;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic l);
        @(negedge refclk);
        rst        = r;
        pll_locked = l;
        modelStep(r, l);
        expQ.push_back(expectedNow());
        cycle++;
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = {pll_rst, sys_rst, lock_ok, state_o, lol_count, timeout_count};
        testsRun++;
        if (a !== e) begin
            failCount++;
            if (failCount <= 20)
                $display("[TB] FAIL outputs@cycle%0d: got pll_rst=%b sys_rst=%b lock_ok=%b state=%b lol=%0d tmo=%0d, expected pll_rst=%b sys_rst=%b lock_ok=%b state=%b lol=%0d tmo=%0d",
                         cycle, a.pllRst, a.sysRst, a.lockOk, a.state, a.lol, a.tmo,
                         e.pllRst, e.sysRst, e.lockOk, e.state, e.lol, e.tmo);
        end
    endtask

    task automatic boundFail(input string what);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: bound expired at cycle %0d, got phase %0d, required target reached", what, cycle, mPhase);
    endtask

    task automatic driveUntil(input logic l, input int ph, input int maxc, input string what);
        int n = 0;
        while (mPhase != ph && n < maxc) begin
            applyStimulus(1'b0, l);
            n++;
        end
        if (mPhase != ph) boundFail(what);
    endtask

    task automatic driveUntilDwell(input logic l, input int ph, input int d, input int maxc, input string what);
        int n = 0;
        while (!(mPhase == ph && mDwell == d) && n < maxc) begin
            applyStimulus(1'b0, l);
            n++;
        end
        if (!(mPhase == ph && mDwell == d)) boundFail(what);
    endtask

    // Monitor: one expected entry per driven cycle, compared shortly after the edge that applied it.
    initial begin
        forever begin
            @(posedge refclk);
            #2;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int seg;
        logic lv;

        repeat (3) applyStimulus(1'b1, 1'b0);

        // Reset release with no lock: PLL pulse, full wait, timeout, second pulse.
        repeat (50) applyStimulus(1'b0, 1'b0);

        // Timeout race: lock reaches the synchronizer exactly on the last wait cycle.
        driveUntil(1'b0, PH_WAIT, 100, "race_wait");
        driveUntilDwell(1'b0, PH_WAIT, TIMEOUT_CYCLES - 3, 100, "race_dwell");
        driveUntil(1'b1, PH_RUN, 40, "race_run");

        // One cycle too late: timeout fires and the PLL is re-pulsed.
        driveUntil(1'b0, PH_WAIT, 10, "late_drop");
        driveUntilDwell(1'b0, PH_WAIT, TIMEOUT_CYCLES - 2, 100, "late_dwell");
        driveUntil(1'b1, PH_RUN, 60, "late_run");

        // Single-cycle glitch during stabilisation forces full re-qualification.
        driveUntil(1'b0, PH_WAIT, 10, "glitch_drop");
        driveUntilDwell(1'b1, PH_STAB, 4, 20, "glitch_stab");
        applyStimulus(1'b0, 1'b0);
        driveUntil(1'b1, PH_RUN, 40, "glitch_run");

        // Repeated loss of lock drives lol_count into saturation.
        for (int i = 0; i < 300; i++) begin
            driveUntil(1'b0, PH_WAIT, 10, "lol_drop");
            driveUntil(1'b1, PH_RUN, 40, "lol_run");
        end
        repeat (3) applyStimulus(1'b0, 1'b1);

        // Mid-run reset aborts everything, then the sequence restarts.
        applyStimulus(1'b1, 1'b1);
        driveUntil(1'b1, PH_RUN, 40, "rerun");

        // Random lock waveform with occasional resets.
        for (int i = 0; i < 1500; i += seg) begin
            seg = $urandom_range(1, 30);
            lv  = 1'($urandom_range(0, 1));
            for (int j = 0; j < seg; j++)
                applyStimulus(($urandom_range(0, 199) == 0), lv);
        end

        repeat (3) @(posedge refclk);
        #3;
        if (expQ.size() != 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL drain: got %0d pending entries, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
